// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  // Fetch control state: normal fetching or draining stale responses.
  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  // One buffered fetch: instruction address, instruction word, misaligned flag.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } fetch_entry_t;

  // Instruction word placed in exception entries (addi x0, x0, 0).
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO of fetch entries. The head is read straight from
// the storage registers (no push-to-head bypass); flush empties it at once.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PZERO = {PW{1'b0}};

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? PZERO : (p + PW'(1'b1));
  endfunction

  assign head = mem[rd_ptr];

  // Storage, pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= {$bits(fetch_entry_t){1'b0}};
      end
      wr_ptr <= PZERO;
      rd_ptr <= PZERO;
      count  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr <= PZERO;
      rd_ptr <= PZERO;
      count  <= {CW{1'b0}};
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word reads for pc_i, pairs in-order
// responses with their request addresses and buffers them for decode.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (misaligned pc_i produces
// an exception entry instead of a memory request).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_i,
  input  logic [31:0] pc_i,
  output logic        pc_adv_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_pc_o,
  output logic        if_exc_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CONE    = CW'(1'b1);
  localparam logic [PW-1:0] LAST    = PW'(FIFO_DEPTH - 1);
  localparam logic [PW-1:0] PZERO   = {PW{1'b0}};

  state_t        state;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] out_next;
  logic [CW:0]   occ;
  logic          stall;
  logic [31:0]   pcq [FIFO_DEPTH];
  logic [PW-1:0] pcq_wr;
  logic [PW-1:0] pcq_rd;

  logic          pop;
  logic          issue;
  logic          misalign;
  logic          grant;
  logic          resp;
  logic          resp_push;
  logic          exc_push;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic          unused_head_exc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? PZERO : (p + PW'(1'b1));
  endfunction

  assign pop         = if_valid_o & if_ready_i;
  assign if_valid_o  = (fifo_cnt != CZERO);
  assign if_inst_o   = head.inst;
  assign if_pc_o     = head.pc;
  assign imem_addr_o = {pc_i[31:2], 2'b00};
  assign pc_adv_o    = grant;

`ifdef FETCH_MISALIGN_CHK_EN
  assign if_exc_o        = head.exc;
  assign unused_head_exc = 1'b0;
`else
  assign if_exc_o        = 1'b0;
  assign unused_head_exc = head.exc;
`endif

  // Issue decision and response classification. The request is combinational
  // so the address tracks pc_i the cycle after an advance; it holds until
  // granted because the PC only moves on a grant.
  always_comb begin
    occ   = {1'b0, out_cnt} + {1'b0, fifo_cnt} - {{CW{1'b0}}, pop};
    issue = (state == S_RUN) & ~rst_sys_i & ~flush_i & ~stall & (occ < DEPTH_W);
`ifdef FETCH_MISALIGN_CHK_EN
    misalign = (pc_i[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    imem_req_o = issue & ~misalign;
    // Wait for older fetches to drain so the exception entry stays in program order.
    exc_push   = issue & misalign & (out_cnt == CZERO);
    grant      = imem_req_o & imem_gnt_i;
    resp       = imem_rvalid_i & (out_cnt != CZERO);
    resp_push  = resp & (state == S_RUN) & ~flush_i;
    out_next   = out_cnt + CW'(grant) - CW'(resp);
    if (resp_push) begin
      push_entry.pc   = pcq[pcq_rd];
      push_entry.inst = imem_rdata_i;
      push_entry.exc  = 1'b0;
    end else begin
      push_entry.pc   = pc_i;
      push_entry.inst = NOP_INST;
      push_entry.exc  = 1'b1;
    end
  end

  // Control FSM with outstanding/drop counters and the misalign stall flag.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state    <= S_RUN;
      out_cnt  <= CZERO;
      drop_cnt <= CZERO;
      stall    <= 1'b0;
    end else begin
      out_cnt <= out_next;
      if (flush_i) begin
        drop_cnt <= out_next;
        stall    <= 1'b0;
        state    <= (out_next != CZERO) ? S_FLUSH : S_RUN;
      end else begin
        case (state)
          S_RUN: begin
            if (exc_push) begin
              stall <= 1'b1;
            end
          end
          S_FLUSH: begin
            if (resp) begin
              drop_cnt <= drop_cnt - CONE;
              if (drop_cnt == CONE) begin
                state <= S_RUN;
              end
            end
          end
          default: begin
            state <= S_RUN;
          end
        endcase
      end
    end
  end

  // Queue of granted request addresses, popped as their responses are buffered.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        pcq[i] <= 32'h0000_0000;
      end
      pcq_wr <= PZERO;
      pcq_rd <= PZERO;
    end else if (flush_i) begin
      pcq_wr <= PZERO;
      pcq_rd <= PZERO;
    end else begin
      if (grant) begin
        pcq[pcq_wr] <= pc_i;
        pcq_wr      <= ptr_inc(pcq_wr);
      end
      if (resp_push) begin
        pcq_rd <= ptr_inc(pcq_rd);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk_sys_i),
    .rst       (rst_sys_i),
    .push      (resp_push | exc_push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush_i),
    .head      (head),
    .count     (fifo_cnt)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table for streaming and grant stalls,
// then hand-written sequences for decode stall, flushes and misaligned fetch.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] TAG = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst_sys_i;
  logic [31:0] pc_i;
  logic        pc_adv_o;
  logic        flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_inst_o;
  logic [31:0] if_pc_o;
  logic        if_exc_o;

  int          checks;
  int          failures;
  int          grant_cnt;
  logic        resp_en;
  logic [31:0] resp_q [$];
  logic [31:0] got_pc [$];
  logic [31:0] got_inst [$];

  typedef struct packed {
    logic        gnt;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        adv;
    logic        valid;
    logic [31:0] ipc;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  fetch_unit #(.FIFO_DEPTH(2), .NOP_INST(32'h0000_0013)) dut (
    .clk_sys_i     (clk),
    .rst_sys_i     (rst_sys_i),
    .pc_i          (pc_i),
    .pc_adv_o      (pc_adv_o),
    .flush_i       (flush_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_ready_i    (if_ready_i),
    .if_inst_o     (if_inst_o),
    .if_pc_o       (if_pc_o),
    .if_exc_o      (if_exc_o)
  );

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Sample at the falling edge, then after the rising edge update the PC and memory models.
  task automatic tick();
    logic        g;
    logic        rv;
    logic [31:0] a;
    logic [31:0] dummy;
    @(negedge clk);
    g  = imem_req_o & imem_gnt_i;
    a  = imem_addr_o;
    rv = imem_rvalid_i;
    if (g) grant_cnt++;
    if (if_valid_o && if_ready_i) begin
      got_pc.push_back(if_pc_o);
      got_inst.push_back(if_inst_o);
    end
    @(posedge clk);
    #1;
    if (rv && resp_q.size() > 0) dummy = resp_q.pop_front();
    if (g) begin
      resp_q.push_back(a);
      pc_i = pc_i + 32'd4;
    end
    imem_rvalid_i = resp_en && (resp_q.size() > 0);
    imem_rdata_i  = imem_rvalid_i ? (TAG | resp_q[0]) : 32'd0;
  endtask

  task automatic rst_on(input logic [31:0] start_pc);
    rst_sys_i = 1'b1;
    flush_i = 1'b0;
    imem_gnt_i = 1'b0;
    if_ready_i = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = 32'd0;
    pc_i = start_pc;
    resp_en = 1'b1;
    resp_q.delete();
    got_pc.delete();
    got_inst.delete();
    grant_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    //          gnt   rdy   req   addr          adv   vld   if_pc         if_inst
    vecs[0]  = {1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = {1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[2]  = {1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 1'b1, 32'h0000_0000, 32'hC0DE_0000};
    vecs[3]  = {1'b1, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 1'b1, 32'h0000_0004, 32'hC0DE_0004};
    vecs[4]  = {1'b0, 1'b1, 1'b1, 32'h0000_0010, 1'b0, 1'b1, 32'h0000_0008, 32'hC0DE_0008};
    vecs[5]  = {1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b1, 32'h0000_000C, 32'hC0DE_000C};
    vecs[6]  = {1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b1, 32'h0000_000C, 32'hC0DE_000C};
    vecs[7]  = {1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_000C, 32'hC0DE_000C};
    vecs[8]  = {1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_000C, 32'hC0DE_000C};
    vecs[9]  = {1'b1, 1'b1, 1'b1, 32'h0000_0014, 1'b1, 1'b1, 32'h0000_000C, 32'hC0DE_000C};
    vecs[10] = {1'b1, 1'b1, 1'b1, 32'h0000_0018, 1'b1, 1'b1, 32'h0000_0010, 32'hC0DE_0010};
    vecs[11] = {1'b1, 1'b1, 1'b1, 32'h0000_001C, 1'b1, 1'b1, 32'h0000_0014, 32'hC0DE_0014};

    // Reset values
    rst_on(32'h0);
    chk1("rst_req", imem_req_o, 1'b0);
    chk1("rst_adv", pc_adv_o, 1'b0);
    chk1("rst_valid", if_valid_o, 1'b0);
    chk32("rst_inst", if_inst_o, 32'h0);
    chk32("rst_pc", if_pc_o, 32'h0);
    chk1("rst_exc", if_exc_o, 1'b0);
    rst_sys_i = 1'b0;

    // Streaming with 1-cycle memory, a 3-cycle grant stall at 0x10 and a decode stall
    for (int i = 0; i < 12; i++) begin
      imem_gnt_i = vecs[i].gnt;
      if_ready_i = vecs[i].ready;
      #2;
      chk1($sformatf("v%0d_req", i), imem_req_o, vecs[i].req);
      if (vecs[i].req) chk32($sformatf("v%0d_addr", i), imem_addr_o, vecs[i].addr);
      chk1($sformatf("v%0d_adv", i), pc_adv_o, vecs[i].adv);
      chk1($sformatf("v%0d_valid", i), if_valid_o, vecs[i].valid);
      if (vecs[i].valid) begin
        chk32($sformatf("v%0d_ifpc", i), if_pc_o, vecs[i].ipc);
        chk32($sformatf("v%0d_inst", i), if_inst_o, vecs[i].inst);
        chk1($sformatf("v%0d_exc", i), if_exc_o, 1'b0);
      end
      tick();
    end

    // Decode stalled for 5 cycles: exactly two grants, head held, nothing lost on release
    rst_on(32'h0);
    rst_sys_i = 1'b0;
    imem_gnt_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      if (i >= 2) chk32($sformatf("s1_hold%0d", i), if_inst_o, TAG);
      tick();
    end
    #2;
    chk32("s1_grants", 32'(grant_cnt), 32'd2);
    chk1("s1_req", imem_req_o, 1'b0);
    chk1("s1_valid", if_valid_o, 1'b1);
    chk32("s1_ifpc", if_pc_o, 32'h0);
    if_ready_i = 1'b1;
    repeat (10) tick();
    chk1("s1_npop", got_pc.size() >= 6, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk32($sformatf("s1_pc%0d", i), got_pc[i], 32'(4 * i));
      chk32($sformatf("s1_inst%0d", i), got_inst[i], TAG | 32'(4 * i));
    end

    // Two requests outstanding, flush with redirect to 0x100
    rst_on(32'h0);
    rst_sys_i = 1'b0;
    resp_en = 1'b0;
    imem_gnt_i = 1'b1;
    if_ready_i = 1'b1;
    tick();
    tick();
    flush_i = 1'b1;
    pc_i = 32'h100;
    #2;
    chk1("s3_flush_req", imem_req_o, 1'b0);
    resp_en = 1'b1;
    tick();
    flush_i = 1'b0;
    #2;
    chk1("s3_drop1_req", imem_req_o, 1'b0);
    chk1("s3_drop1_valid", if_valid_o, 1'b0);
    tick();
    #2;
    chk1("s3_drop2_req", imem_req_o, 1'b0);
    chk1("s3_drop2_valid", if_valid_o, 1'b0);
    tick();
    #2;
    chk1("s3_resume_req", imem_req_o, 1'b1);
    chk32("s3_resume_addr", imem_addr_o, 32'h100);
    tick();
    #2;
    chk1("s3_lat_valid", if_valid_o, 1'b0);
    tick();
    #2;
    chk1("s3_new_valid", if_valid_o, 1'b1);
    chk32("s3_new_pc", if_pc_o, 32'h100);
    chk32("s3_new_inst", if_inst_o, TAG | 32'h100);

    // Flush in the same cycle as gnt and a response, with a full-ish buffer
    rst_on(32'h0);
    rst_sys_i = 1'b0;
    imem_gnt_i = 1'b1;
    tick();
    tick();
    flush_i = 1'b1;
    pc_i = 32'h200;
    #2;
    chk1("s4_rvalid_seen", imem_rvalid_i, 1'b1);
    chk1("s4_flush_valid", if_valid_o, 1'b1);
    chk1("s4_flush_adv", pc_adv_o, 1'b0);
    chk1("s4_flush_req", imem_req_o, 1'b0);
    tick();
    flush_i = 1'b0;
    if_ready_i = 1'b1;
    #2;
    chk1("s4_post_valid", if_valid_o, 1'b0);
    chk1("s4_post_req", imem_req_o, 1'b1);
    chk32("s4_post_addr", imem_addr_o, 32'h200);
    tick();
    #2;
    chk1("s4_lat_valid", if_valid_o, 1'b0);
    tick();
    #2;
    chk1("s4_new_valid", if_valid_o, 1'b1);
    chk32("s4_new_pc", if_pc_o, 32'h200);

    // Misaligned fetch address 0x22
    rst_on(32'h22);
    rst_sys_i = 1'b0;
    imem_gnt_i = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
    #2;
    chk1("s5_req", imem_req_o, 1'b0);
    chk1("s5_adv", pc_adv_o, 1'b0);
    tick();
    #2;
    chk1("s5_valid", if_valid_o, 1'b1);
    chk1("s5_exc", if_exc_o, 1'b1);
    chk32("s5_inst", if_inst_o, 32'h0000_0013);
    chk32("s5_pc", if_pc_o, 32'h22);
    chk1("s5_stall_req", imem_req_o, 1'b0);
    tick();
    #2;
    chk1("s5_stall2_req", imem_req_o, 1'b0);
    flush_i = 1'b1;
    pc_i = 32'h40;
    tick();
    flush_i = 1'b0;
    #2;
    chk1("s5_resume_req", imem_req_o, 1'b1);
    chk32("s5_resume_addr", imem_addr_o, 32'h40);
`else
    if_ready_i = 1'b0;
    #2;
    chk1("s5_req", imem_req_o, 1'b1);
    chk32("s5_addr", imem_addr_o, 32'h20);
    tick();
    tick();
    #2;
    chk1("s5_valid", if_valid_o, 1'b1);
    chk1("s5_exc", if_exc_o, 1'b0);
    chk32("s5_pc", if_pc_o, 32'h22);
    chk32("s5_inst", if_inst_o, TAG | 32'h20);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly downstream of the program counter. Takes the current fetch address, issues word reads to instruction memory over a request/grant/response handshake, and tells the PC when to advance. Returned instructions are buffered with their addresses in a small FIFO and handed to decode over a valid/ready handshake. A flush discards buffered and in-flight fetches after a redirect.

## Interface
- FIFO_DEPTH, 2: instruction buffer entries; also the cap on outstanding plus buffered fetches (≥2).
- NOP_INST, 32'h0000_0013: instruction word placed in exception entries.
- clk_sys_i  in  1  system clock, rising edge.
- rst_sys_i  in  1  reset, synchronous, active-high.
- pc_i  in  32  current fetch address from PC.
- pc_adv_o  out  1  advance PC by 4; drives PC add4_en_i.
- flush_i  in  1  discard all buffered and in-flight fetches.
- imem_req_o  out  1  memory read request.
- imem_addr_o  out  32  word-aligned request address.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response valid; responses return in order.
- imem_rdata_i  in  32  response instruction word.
- if_valid_o  out  1  decode entry valid.
- if_ready_i  in  1  decode accepts entry.
- if_inst_o  out  32  instruction.
- if_pc_o  out  32  address of if_inst_o.
- if_exc_o  out  1  misaligned-fetch flag (0 when FETCH_MISALIGN_CHK_EN is undefined).

## Operation
- State machine states:
  - S_RUN: normal fetch.
  - S_FLUSH: drop in-flight responses; no requests issued.
- Counters:
  - out_cnt: granted requests with no response yet.
  - fifo_cnt: buffer occupancy.
  - drop_cnt: responses still to discard.
  - All counters are $clog2(FIFO_DEPTH+1) bits wide.
- pop = if_valid_o & if_ready_i.
- Issue condition, in S_RUN only: out_cnt + fifo_cnt − pop < FIFO_DEPTH and flush_i = 0.
- Request handshake:
  - Once imem_req_o is asserted, it and imem_addr_o hold until imem_gnt_i, unless flush_i.
  - imem_addr_o = {pc_i[31:2], 2'b00}.
  - The request PC is captured per outstanding slot (a queue of depth FIFO_DEPTH) so it can be paired with its response.
- pc_adv_o = imem_req_o & imem_gnt_i. This is the only cycle the PC advances.
- Response: imem_rvalid_i pushes {captured pc, imem_rdata_i, exc=0} into the FIFO and decrements out_cnt. imem_rvalid_i with out_cnt = 0 is ignored.
- Flush:
  - flush_i empties the FIFO and drops any ungranted request.
  - drop_cnt is loaded with out_cnt, plus 1 if a grant occurs that cycle, minus 1 if a response arrives that cycle.
  - If drop_cnt > 0 → S_FLUSH. Otherwise stay in S_RUN; issue may resume the next cycle from the new pc_i.
  - Each response in S_FLUSH decrements drop_cnt and is not pushed. drop_cnt reaching 0 → S_RUN.
  - flush_i while in S_FLUSH reloads drop_cnt the same way.
- Simultaneous push and pop: occupancy unchanged. Push into a full FIFO cannot occur because of the issue condition.

## Timing
- Reset values: imem_req_o=0, pc_adv_o=0, if_valid_o=0, if_inst_o=0, if_pc_o=0, if_exc_o=0, all counters 0, FIFO empty, state S_RUN.
- First request: cycle after rst_sys_i deasserts.
- Latency: rvalid in cycle N → if_valid_o in N+1 (registered FIFO head, no bypass).
- Throughput: one instruction per cycle with 1-cycle memory, always-ready decode, FIFO_DEPTH=2.
- if_valid_o, if_inst_o, if_pc_o and if_exc_o hold while if_ready_i=0.
- flush_i in cycle N → if_valid_o=0 in N+1.

## Configuration
- FETCH_MISALIGN_CHK_EN defined:
  - When the issue condition holds and pc_i[1:0] ≠ 0, no memory request is made.
  - Instead, {pc_i, NOP_INST, exc=1} is pushed directly, with pc_adv_o=0.
  - The stage then stalls, issuing nothing, until flush_i.
- Undefined: pc_i[1:0] ignored; if_exc_o tied to 0.

## Structure
- Package fetch_pkg holds:
  - state enum {S_RUN, S_FLUSH};
  - the fetch entry struct {pc[31:0], inst[31:0], exc};
  - the NOP_INST default.
- Sub-module fetch_fifo: parameterised synchronous FIFO of entries with push, pop, flush and count.

## Test plan
- Reset then 1-cycle memory, pc_i=0x0 → imem_addr_o 0x0, 0x4, 0x8 on consecutive cycles; if_pc_o 0x0, 0x4, 0x8 from cycle 3, one per cycle.
- if_ready_i=0 for 5 cycles → exactly 2 requests granted, then imem_req_o=0; if_inst_o stable; on release, no entries lost or duplicated.
- imem_gnt_i low 3 cycles with req at 0x10 → imem_addr_o held at 0x10, pc_adv_o=0 until the grant cycle.
- Two requests outstanding, flush_i, new pc_i=0x100 → S_FLUSH, two responses dropped, next if_pc_o=0x100.
- flush_i in the same cycle as a grant and a response → drop_cnt correct; no stale entry reaches decode.
- With FETCH_MISALIGN_CHK_EN, pc_i=0x22 → no request; if_exc_o=1, if_inst_o=0x00000013, if_pc_o=0x22.
